rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Owns the single write port of the 32x32 register file (x0 hard-wired zero).
- Arbitrates round-robin between NREQ writeback requesters (ALU, LSU, ...) using a valid/ready handshake, and registers the winner onto the register-file write port.
- Keeps a pending-write scoreboard so issue logic can stall on RAW/WAW hazards.
- Sits between the execute/memory units and the register file.

Parameters:
- NREQ, 2, number of writeback requesters (2..4).
- XLEN, 32, data width.
- REG_AW, 5, register address width (32 registers).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  requester i has a write pending.
- req_ready  output  NREQ  one-hot grant; request i accepted when req_valid[i] & req_ready[i].
- req_rd  input  NREQ x REG_AW  destination register per requester.
- req_data  input  NREQ x XLEN  write data per requester.
- issue_valid  input  1  issue stage reserves a destination this cycle.
- issue_rd  input  REG_AW  destination being reserved.
- issue_ready  output  1  reservation allowed (no WAW).
- rs1, rs2  input  REG_AW  source registers of the instruction at issue.
- rs1_busy, rs2_busy  output  1  source has an uncommitted write (RAW stall).
- rf_rd  output  REG_AW  to register file rd.
- rf_data_write  output  XLEN  to register file data_write.
- rf_reg_write  output  1  to register file reg_write.
- busy  output  32  scoreboard bitmap, bit 0 always 0.

Behaviour:
- Reset (reset=1 at a clock edge): rr_ptr=0, busy=0, rf_reg_write=0, rf_rd=0, rf_data_write=0. req_ready is combinational and is all-zero while reset=1.
- Arbitration: combinational. Search for the first valid requester starting at rr_ptr and wrapping modulo NREQ. Assert req_ready only for that winner, so at most one bit is set. No valid request gives req_ready=0.
- Acceptance: the winner is accepted in the cycle it is granted. There is no backpressure from the register file, so a grant is always possible when any request is valid.
- rr_ptr: on acceptance of index g, the next rr_ptr is (g+1) mod NREQ. With no acceptance, rr_ptr holds.
- Latency: exactly 1 cycle. On the edge after acceptance: rf_reg_write=1, rf_rd=req_rd[g], rf_data_write=req_data[g]. With no acceptance the next cycle has rf_reg_write=0 and rf_rd/rf_data_write hold their last values.
- Writes to x0 are accepted, but the registered rf_reg_write is 0 for them.
- Scoreboard set: on issue_valid & issue_ready & issue_rd!=0, busy[issue_rd] is set at the edge.
- Scoreboard clear: while rf_reg_write=1, busy[rf_rd] is cleared at the end of that cycle.
- Simultaneous set and clear of the same register in one cycle: set wins and the bit stays 1.
- issue_ready = ~busy[issue_rd] | (issue_rd==0). A second reservation to a busy register is refused (WAW).
- rsN_busy = busy[rsN] & (rsN!=0). A register committing in the current cycle still reads busy. No bypass: the register file shows the new value from the next cycle.
- Requesters must not send a write for a register they did not reserve. Such a write commits normally, and its clear is a no-op if the bit is 0.
- Reset mid-operation:
  - Any accepted but uncommitted write is dropped: rf_reg_write=0 in the cycle after reset.
  - busy is cleared; the register file contents are not touched by this block.
- req_valid deasserted before grant: no effect and no pointer change. Requesters hold req_rd/req_data stable while valid and not ready.

Decomposition:
- Shared package rv_pkg:
  - XLEN, REG_AW, NUM_REGS=32.
  - typedef reg_addr_t (logic [REG_AW-1:0]).
  - typedef wb_req_t struct {valid, rd, data}.
- One sub-module: rr_arbiter (parameter N; inputs req, ptr; output one-hot gnt). It is reused later for memory-port sharing.
- Scoreboard bitmap and output register stay inline.

Test Plan:
- Reset then idle: assert reset for 2 cycles with random req_valid -> req_ready=0 during reset; afterwards busy=0, rf_reg_write=0, rr_ptr=0.
- Single write: issue_rd=5 reserved; next cycle rs1=5 -> rs1_busy=1. req0 writes rd=5, data=0xDEADBEEF -> rf_reg_write=1, rf_rd=5, rf_data_write=0xDEADBEEF one cycle after acceptance. busy[5] reads 1 during that cycle and 0 after it.
- Contention: req0 and req1 valid every cycle with NREQ=2 -> grants alternate 0,1,0,1 starting with 0. Each rf write appears 1 cycle after its grant, with no lost or duplicated writes.
- x0 handling: request rd=0, data=0x1234 -> req_ready asserted, next cycle rf_reg_write=0. issue_rd=0 -> issue_ready=1 and busy stays 0.
- WAW / set-clear collision:
  - busy[7]=1 -> issue_rd=7 gives issue_ready=0.
  - In the cycle rf commits rd=7, issue_rd=7 is still refused (busy=1).
  - In a separate check, a forced set of 7 in the clear cycle leaves busy[7]=1.
- Reset mid-flight: accept a write to rd=3, then assert reset on the next edge -> rf_reg_write=0 afterwards and busy[3]=0.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file widths and writeback request types
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic            valid;
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant searching upward from ptr
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            // Candidate index is (ptr + k) mod N, kept narrow to avoid a divider.
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register-file write-port arbiter with pending-write scoreboard
module rf_wb_scheduler #(
    parameter int NREQ   = 2,
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int REG_AW = rv_pkg::REG_AW
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][REG_AW-1:0] req_rd,
    input  logic [NREQ-1:0][XLEN-1:0]  req_data,
    input  logic                       issue_valid,
    input  logic [REG_AW-1:0]          issue_rd,
    output logic                       issue_ready,
    input  logic [REG_AW-1:0]          rs1,
    input  logic [REG_AW-1:0]          rs2,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic [REG_AW-1:0]          rf_rd,
    output logic [XLEN-1:0]            rf_data_write,
    output logic                       rf_reg_write,
    output logic [31:0]                busy
);

    import rv_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    wb_req_t             wb_q, wb_d;

    logic [NREQ-1:0]   gnt;
    logic              accept;
    logic [PW-1:0]     win_idx;
    logic [REG_AW-1:0] win_rd;
    logic [XLEN-1:0]   win_data;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    assign req_ready = reset ? '0 : gnt;
    assign accept    = |req_ready;

    always_comb begin
        win_idx  = '0;
        win_rd   = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                win_idx  = PW'(i);
                win_rd   = req_rd[i];
                win_data = req_data[i];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
        end
    end

    // x0 writes are consumed here so the register file never sees them.
    always_comb begin
        wb_d.valid = accept && (win_rd != '0);
        wb_d.rd    = accept ? win_rd   : wb_q.rd;
        wb_d.data  = accept ? win_data : wb_q.data;
    end

    assign issue_ready = ~busy_q[issue_rd] | (issue_rd == '0);
    assign rs1_busy    = busy_q[rs1] & (rs1 != '0);
    assign rs2_busy    = busy_q[rs2] & (rs2 != '0);

    // Set is applied after clear so a same-cycle reservation survives the commit.
    always_comb begin
        busy_d = busy_q;
        if (wb_q.valid) begin
            busy_d[wb_q.rd] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rr_ptr_q <= '0;
            busy_q   <= '0;
            wb_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            wb_q     <= wb_d;
        end
    end

    assign rf_reg_write  = wb_q.valid;
    assign rf_rd         = wb_q.rd;
    assign rf_data_write = wb_q.data;
    assign busy          = busy_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - vector table plus write scoreboard for rf_wb_scheduler
module tb_rf_wb_scheduler;

    logic             CLK = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][4:0]  req_rd;
    logic [1:0][31:0] req_data;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             issue_ready;
    logic [4:0]       rs1, rs2;
    logic             rs1_busy, rs2_busy;
    logic [4:0]       rf_rd;
    logic [31:0]      rf_data_write;
    logic             rf_reg_write;
    logic [31:0]      busy;

    always #5 CLK = ~CLK;

    rf_wb_scheduler #(.NREQ(2), .XLEN(32), .REG_AW(5)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rd        (req_rd),
        .req_data      (req_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rf_rd         (rf_rd),
        .rf_data_write (rf_data_write),
        .rf_reg_write  (rf_reg_write),
        .busy          (busy)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  rv;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [1:0]  rdy;
        logic        irdy;
        logic        s1b;
        logic        s2b;
        logic [31:0] bsy;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    localparam int NV = 24;
    vec_t tbl[NV];
    wr_t  exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic rst, logic [1:0] rv, logic [4:0] rd0, logic [31:0] d0,
                                logic [4:0] rd1, logic [31:0] d1, logic iv, logic [4:0] ird,
                                logic [4:0] s1, logic [4:0] s2, logic [1:0] rdy, logic irdy,
                                logic s1b, logic s2b, logic [31:0] bsy);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rd0 = rd0; v.d0 = d0; v.rd1 = rd1; v.d1 = d1;
        v.iv = iv; v.ird = ird; v.s1 = s1; v.s2 = s2; v.rdy = rdy; v.irdy = irdy;
        v.s1b = s1b; v.s2b = s2b; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rf_check(input string tag, input bit rst_cyc);
        wr_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " rf_reg_write"}, 32'(rf_reg_write), 32'(e.we));
            if (e.we) begin
                chk({tag, " rf_rd"}, 32'(rf_rd), 32'(e.rd));
                chk({tag, " rf_data"}, rf_data_write, e.data);
            end
        end else if (!rst_cyc) begin
            chk({tag, " rf_reg_write idle"}, 32'(rf_reg_write), 32'd0);
        end
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [4:0] rd0, input logic [31:0] d0,
                            input logic [4:0] rd1, input logic [31:0] d1);
        wr_t e;
        e.we = 1'b0; e.rd = '0; e.data = '0;
        if (g[0]) begin
            e.we = (rd0 != 0); e.rd = rd0; e.data = d0;
        end else if (g[1]) begin
            e.we = (rd1 != 0); e.rd = rd1; e.data = d1;
        end
        exp_q.push_back(e);
    endtask

    initial begin
        logic [1:0]  g;
        logic        ptr;
        logic [4:0]  r0, r1;
        logic [31:0] x0, x1;
        string       tag;

        reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;

        //         rst rv     rd0 d0            rd1 d1        iv ird s1 s2 rdy    irdy s1b s2b bsy
        tbl[0]  = mk(1, 2'b11, 1,  32'h1,        2,  32'h2,    0, 0,  0, 0, 2'b00, 0,   0,  0,  32'h0);
        tbl[1]  = mk(1, 2'b10, 3,  32'h3,        4,  32'h4,    0, 0,  0, 0, 2'b00, 0,   0,  0,  32'h0);
        tbl[2]  = mk(0, 2'b11, 10, 32'hA0,       11, 32'hB1,   0, 0,  0, 0, 2'b01, 1,   0,  0,  32'h0);
        tbl[3]  = mk(0, 2'b11, 12, 32'hA2,       13, 32'hB3,   0, 0,  0, 0, 2'b10, 1,   0,  0,  32'h0);
        tbl[4]  = mk(0, 2'b11, 14, 32'hA4,       15, 32'hB5,   0, 0,  0, 0, 2'b01, 1,   0,  0,  32'h0);
        tbl[5]  = mk(0, 2'b11, 16, 32'hA6,       17, 32'hB7,   0, 0,  0, 0, 2'b10, 1,   0,  0,  32'h0);
        tbl[6]  = mk(0, 2'b00, 0,  32'h0,        0,  32'h0,    1, 5,  5, 0, 2'b00, 1,   0,  0,  32'h0);
        tbl[7]  = mk(0, 2'b01, 5,  32'hDEADBEEF, 0,  32'h0,    1, 5,  5, 0, 2'b01, 0,   1,  0,  32'h20);
        tbl[8]  = mk(0, 2'b00, 0,  32'h0,        0,  32'h0,    0, 5,  5, 0, 2'b00, 0,   1,  0,  32'h20);
        tbl[9]  = mk(0, 2'b00, 0,  32'h0,        0,  32'h0,    0, 5,  5, 0, 2'b00, 1,   0,  0,  32'h0);
        tbl[10] = mk(0, 2'b10, 0,  32'h0,        0,  32'h1234, 1, 0,  0, 0, 2'b10, 1,   0,  0,  32'h0);
        tbl[11] = mk(0, 2'b00, 0,  32'h0,        0,  32'h0,    1, 0,  0, 0, 2'b00, 1,   0,  0,  32'h0);
        tbl[12] = mk(0, 2'b00, 0,  32'h0,        0,  32'h0,    1, 7,  0, 7, 2'b00, 1,   0,  0,  32'h0);
        tbl[13] = mk(0, 2'b01, 7,  32'h77,       0,  32'h0,    1, 7,  0, 7, 2'b01, 0,   0,  1,  32'h80);
        tbl[14] = mk(0, 2'b00, 0,  32'h0,        0,  32'h0,    1, 7,  0, 7, 2'b00, 0,   0,  1,  32'h80);
        tbl[15] = mk(0, 2'b00, 0,  32'h0,        0,  32'h0,    0, 7,  0, 7, 2'b00, 1,   0,  0,  32'h0);
        tbl[16] = mk(0, 2'b10, 0,  32'h0,        7,  32'h88,   0, 7,  0, 7, 2'b10, 1,   0,  0,  32'h0);
        tbl[17] = mk(0, 2'b00, 0,  32'h0,        0,  32'h0,    1, 7,  0, 7, 2'b00, 1,   0,  0,  32'h0);
        tbl[18] = mk(0, 2'b00, 0,  32'h0,        0,  32'h0,    0, 7,  0, 7, 2'b00, 0,   0,  1,  32'h80);
        tbl[19] = mk(0, 2'b00, 0,  32'h0,        0,  32'h0,    1, 3,  3, 0, 2'b00, 1,   0,  0,  32'h80);
        tbl[20] = mk(0, 2'b01, 3,  32'h333,      0,  32'h0,    0, 0,  3, 0, 2'b01, 1,   1,  0,  32'h88);
        tbl[21] = mk(1, 2'b01, 9,  32'h999,      0,  32'h0,    1, 9,  0, 0, 2'b00, 0,   0,  0,  32'h0);
        tbl[22] = mk(0, 2'b11, 20, 32'hC0,       21, 32'hC1,   0, 0,  3, 0, 2'b01, 1,   0,  0,  32'h0);
        tbl[23] = mk(0, 2'b00, 0,  32'h0,        0,  32'h0,    0, 0,  0, 0, 2'b00, 1,   0,  0,  32'h0);

        for (int i = 0; i < NV; i++) begin
            @(posedge CLK); #1;
            reset       = tbl[i].rst;
            req_valid   = tbl[i].rv;
            req_rd[0]   = tbl[i].rd0; req_data[0] = tbl[i].d0;
            req_rd[1]   = tbl[i].rd1; req_data[1] = tbl[i].d1;
            issue_valid = tbl[i].iv;  issue_rd    = tbl[i].ird;
            rs1         = tbl[i].s1;  rs2         = tbl[i].s2;
            @(negedge CLK);
            tag = $sformatf("row%0d", i);
            rf_check(tag, tbl[i].rst);
            chk({tag, " req_ready"}, 32'(req_ready), 32'(tbl[i].rdy));
            if (tbl[i].rst) begin
                exp_q.delete();
            end else begin
                chk({tag, " issue_ready"}, 32'(issue_ready), 32'(tbl[i].irdy));
                chk({tag, " rs1_busy"}, 32'(rs1_busy), 32'(tbl[i].s1b));
                chk({tag, " rs2_busy"}, 32'(rs2_busy), 32'(tbl[i].s2b));
                chk({tag, " busy"}, busy, tbl[i].bsy);
                push_exp(tbl[i].rdy, tbl[i].rd0, tbl[i].d0, tbl[i].rd1, tbl[i].d1);
            end
        end

        // Sustained contention: pointer sits at 1 after row22 granted requester 0.
        ptr = 1'b1;
        issue_valid = 1'b0; rs1 = '0; rs2 = '0;
        for (int c = 0; c < 10; c++) begin
            r0 = 5'($urandom_range(0, 31)); x0 = $urandom;
            r1 = 5'($urandom_range(0, 31)); x1 = $urandom;
            @(posedge CLK); #1;
            reset     = 1'b0;
            req_valid = (c < 8) ? 2'b11 : 2'b00;
            req_rd[0] = r0; req_data[0] = x0;
            req_rd[1] = r1; req_data[1] = x1;
            @(negedge CLK);
            tag = $sformatf("cont%0d", c);
            rf_check(tag, 1'b0);
            g = (c < 8) ? (ptr ? 2'b10 : 2'b01) : 2'b00;
            chk({tag, " req_ready"}, 32'(req_ready), 32'(g));
            chk({tag, " busy"}, busy, 32'h0);
            push_exp(g, r0, x0, r1, x1);
            if (g != 2'b00) ptr = ~ptr;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
